leaf_stage_fifo: RTL and testbench

LEAF_STAGE_FIFO -- requirements
Module: leaf_stage_fifo

---
 rtl/leaf_stage_fifo.sv | 71 +++++++
 tb/tb_leaf_stage_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stage_fifo.sv
// First-word fall-through FIFO with occupancy and peak-occupancy tracking; push visible after 1 cycle.
// Upstream is throttled by in_ready, which is taken from registered count only (no out_ready path).
module leaf_stage_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   peak
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A flush cycle swallows any handshake that would otherwise occur.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      peak   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      peak   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (count_nxt > peak) peak <= count_nxt;
    end
  end

  // Storage is never cleared; only entries between rd_ptr and wr_ptr are observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_leaf_stage_fifo.sv
// Directed bench for leaf_stage_fifo: stimulus queues expected pops, a negedge monitor checks them.
module tb_leaf_stage_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
  logic [2:0] peak;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [7:0] exp_q[$];

  leaf_stage_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .peak(peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; the bench decides acceptance from its own occupancy count.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (ordy && mcount != 0) mcount--;
      if (iv && (mcount < 4 || (ordy && 0))) begin
      end
      if (iv && (mcount + (ordy && mcount_pre_nonzero(mcount, ordy) ? 0 : 0)) < 4) begin
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit mcount_pre_nonzero(input int c, input logic r);
    return (c != 0) && r;
  endfunction

  // Acceptance is decided on the pre-cycle occupancy: a full FIFO refuses a push even while popping.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    bit acc_push;
    bit acc_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      acc_push = iv && (mcount < 4);
      acc_pop  = ordy && (mcount != 0);
      if (acc_push) begin
        exp_q.push_back(d);
        mcount++;
      end
      if (acc_pop) mcount--;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", out_data, $time);
      end else begin
        chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Fill with no drain, then drain in order
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk("fwft_valid", int'(out_valid), 1);
    chk("fwft_data", int'(out_data), 'h11);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    chk("hold_data", int'(out_data), 'h11);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("full_reject_count", int'(count), 4);
    chk("hold_data2", int'(out_data), 'h11);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_count", int'(count), 0);
    chk("drain_peak", int'(peak), 4);
    chk("drain_out_valid", int'(out_valid), 0);

    // Clear peak, then stream 16 words through with continuous push and pop
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_peak", int'(peak), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b1, 1'b0);
      chk("stream_count", int'(count), 1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_end_count", int'(count), 0);
    chk("stream_peak", int'(peak), 1);

    // Full with simultaneous pop: pop wins, push retried next cycle
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("full_pop_count", int'(count), 3);
    chk("full_pop_head", int'(out_data), 'hA1);
    cyc(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("retry_count", int'(count), 4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("retry_drain_count", int'(count), 0);

    // Flush with a concurrent push
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hBF;
    flush    = 1'b1;
    #1;
    chk("preflush_out_valid", int'(out_valid), 1);
    chk("preflush_in_ready", int'(in_ready), 1);
    chk("preflush_count", int'(count), 3);
    cyc(1'b1, 8'hBF, 1'b0, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_peak2", int'(peak), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hC1, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("postflush_count", int'(count), 0);

    // Asynchronous reset mid-cycle with two entries held
    cyc(1'b1, 8'hD1, 1'b0, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_count", int'(count), 0);
    exp_q.delete();
    mcount = 0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ignore_count", int'(count), 0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("after_rst_count", int'(count), 1);
    chk("after_rst_head", int'(out_data), 'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("after_rst_drain", int'(count), 0);

    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
